fp128_mul_norm_round: RTL and testbench

FP128_MUL_NORM_ROUND -- requirements
Module: fp128_mul_norm_round

---
 rtl/fp128_mul_norm_round.sv | 213 +++++++++++++++++++++
 tb/tb_fp128_mul_norm_round.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp128_mul_norm_round.sv
// fp128_mul_norm_round: normalise, round and pack stage for a binary128 multiplier.
// Takes the raw 226-bit significand product, the sign and the biased exponent sum. It then walks
// IDLE -> NORM -> RND -> PACK, one state per clock, and registers an IEEE binary128 result.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   ld        start pulse, sampled only in IDLE
//   prod_i    raw product of two 113-bit significands (bits [255:226] are zero)
//   sign_i    result sign
//   exp_i     signed biased exponent sum ea+eb-16383
//   rm        rounding mode (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM)
//   o         packed binary128 result, held until the next done
//   done      one-cycle completion pulse
//   busy      high whenever an operation is in flight
//   overflow, underflow, inexact  result flags, held with o
//
// Configuration: define FP128_MUL_RM_EN to honour all five rounding modes. Without it, rm is
// ignored, rounding is RNE only and overflow always yields infinity.
module fp128_mul_norm_round (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [255:0] prod_i,
    input  logic         sign_i,
    input  logic [17:0]  exp_i,
    input  logic [2:0]   rm,
    output logic [127:0] o,
    output logic         done,
    output logic         busy,
    output logic         overflow,
    output logic         underflow,
    output logic         inexact
);

    typedef enum logic [1:0] {StIdle, StNorm, StRnd, StPack} state_e;

    localparam logic [2:0] RmRne = 3'd0;
    localparam logic [2:0] RmRtz = 3'd1;
    localparam logic [2:0] RmRdn = 3'd2;
    localparam logic [2:0] RmRup = 3'd3;
    localparam logic [2:0] RmRmm = 3'd4;

    state_e              state_q, state_d;
    logic [225:0]        prod_q, prod_d;
    logic                sign_q, sign_d;
    // Two spare bits keep the +1 adjustments and the negative range exact.
    logic signed [19:0]  exp_q, exp_d;
    logic [2:0]          rm_q, rm_d;
    logic [111:0]        frac_q, frac_d;
    logic                guard_q, guard_d;
    logic                sticky_q, sticky_d;
    logic                zero_q, zero_d;
    logic [127:0]        o_q, o_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                inx_q, inx_d;

    logic                rnd_inc;
    logic [112:0]        rnd_sum;
    logic                ovf_max;
    logic                unused_prod_hi;

    // The multiplier guarantees these bits are zero.
    assign unused_prod_hi = |prod_i[255:226];

`ifdef FP128_MUL_RM_EN
    always_comb begin
        rnd_inc = 1'b0;
        unique case (rm_q)
            RmRtz:   rnd_inc = 1'b0;
            RmRdn:   rnd_inc = (guard_q | sticky_q) & sign_q;
            RmRup:   rnd_inc = (guard_q | sticky_q) & ~sign_q;
            RmRmm:   rnd_inc = guard_q;
            default: rnd_inc = guard_q & (sticky_q | frac_q[0]);
        endcase
    end

    // Modes that round toward zero for this sign saturate at max finite instead of infinity.
    assign ovf_max = (rm_q == RmRtz) || ((rm_q == RmRdn) && !sign_q) ||
                     ((rm_q == RmRup) && sign_q);
`else
    logic unused_rm;

    assign unused_rm = (rm_q == RmRne) ^ (rm_q == RmRtz) ^ (rm_q == RmRdn) ^
                       (rm_q == RmRup) ^ (rm_q == RmRmm);
    assign rnd_inc   = guard_q & (sticky_q | frac_q[0]);
    assign ovf_max   = 1'b0;
`endif

    assign rnd_sum = {1'b0, frac_q} + {112'd0, rnd_inc};

    always_comb begin
        state_d  = state_q;
        prod_d   = prod_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        rm_d     = rm_q;
        frac_d   = frac_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        zero_d   = zero_q;
        o_d      = o_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;

        unique case (state_q)
            StIdle: begin
                if (ld) begin
                    prod_d  = prod_i[225:0];
                    sign_d  = sign_i;
                    exp_d   = {{2{exp_i[17]}}, exp_i};
                    rm_d    = rm;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                zero_d = (prod_q == '0);
                // Product of two [1,2) significands lies in [1,4): bit 225 marks the upper half.
                if (prod_q[225]) begin
                    frac_d   = prod_q[224:113];
                    guard_d  = prod_q[112];
                    sticky_d = |prod_q[111:0];
                    exp_d    = exp_q + 20'sd1;
                end else begin
                    frac_d   = prod_q[223:112];
                    guard_d  = prod_q[111];
                    sticky_d = |prod_q[110:0];
                end
                state_d = StRnd;
            end
            StRnd: begin
                // A carry out only occurs from all-ones, so the low bits of the sum are zero.
                frac_d  = rnd_sum[111:0];
                exp_d   = exp_q + {19'd0, rnd_sum[112]};
                state_d = StPack;
            end
            StPack: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (zero_q) begin
                    o_d   = {sign_q, 127'd0};
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    inx_d = 1'b0;
                end else if (exp_q >= 20'sd32767) begin
                    o_d   = ovf_max ? {sign_q, 15'h7FFE, {112{1'b1}}}
                                    : {sign_q, 15'h7FFF, 112'd0};
                    ovf_d = 1'b1;
                    unf_d = 1'b0;
                    inx_d = 1'b1;
                end else if (exp_q <= 20'sd0) begin
                    // Flush to zero; subnormals are not produced.
                    o_d   = {sign_q, 127'd0};
                    ovf_d = 1'b0;
                    unf_d = 1'b1;
                    inx_d = 1'b1;
                end else begin
                    o_d   = {sign_q, exp_q[14:0], frac_q};
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    inx_d = guard_q | sticky_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            prod_q   <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            rm_q     <= '0;
            frac_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            zero_q   <= 1'b0;
            o_q      <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prod_q   <= prod_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            rm_q     <= rm_d;
            frac_q   <= frac_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            zero_q   <= zero_d;
            o_q      <= o_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

    assign o         = o_q;
    assign done      = done_q;
    assign busy      = (state_q != StIdle);
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;

endmodule

// File: tb/tb_fp128_mul_norm_round.sv
// Self-checking bench for fp128_mul_norm_round: directed corner cases followed by random
// products, all checked against an arithmetic reference model.
module tb_fp128_mul_norm_round;

    logic         clk;
    logic         rst_n;
    logic         ld;
    logic [255:0] prod_i;
    logic         sign_i;
    logic [17:0]  exp_i;
    logic [2:0]   rm;
    logic [127:0] o;
    logic         done;
    logic         busy;
    logic         overflow;
    logic         underflow;
    logic         inexact;

    int ncmp;
    int nfail;

    fp128_mul_norm_round dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld        (ld),
        .prod_i    (prod_i),
        .sign_i    (sign_i),
        .exp_i     (exp_i),
        .rm        (rm),
        .o         (o),
        .done      (done),
        .busy      (busy),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        ncmp++;
        assert (act === exp) else begin
            nfail++;
            $error("FAIL %s: got %h required %h", tag, act, exp);
        end
    endtask

    // Reference: value-level rounding of prod * 2^(exp-16383-224) into binary128.
    // Returns result and flags {overflow, underflow, inexact}.
    function automatic void model(input logic [255:0] p, input logic s,
                                  input logic signed [17:0] e, input logic [2:0] r,
                                  output logic [127:0] ro, output logic [2:0] rf);
        int          sh;
        int          ex;
        logic [255:0] fr;
        logic [255:0] rem;
        logic [255:0] half;
        logic        g;
        logic        st;
        logic        inc;
        logic        maxf;
        ex = e;
        if (p == 0) begin
            ro = {s, 127'd0};
            rf = 3'b000;
            return;
        end
        sh = (p >= (256'd1 << 225)) ? 113 : 112;
        if (sh == 113) ex = ex + 1;
        fr   = p >> sh;
        rem  = p - (fr << sh);
        half = 256'd1 << (sh - 1);
        g    = rem >= half;
        st   = g ? (rem != half) : (rem != 0);
        fr   = fr - (256'd1 << 112);
        inc  = g & (st | fr[0]);
        maxf = 1'b0;
`ifdef FP128_MUL_RM_EN
        case (r)
            3'd1: inc = 1'b0;
            3'd2: inc = (g | st) & s;
            3'd3: inc = (g | st) & ~s;
            3'd4: inc = g;
            default: inc = g & (st | fr[0]);
        endcase
        maxf = (r == 3'd1) || (r == 3'd2 && !s) || (r == 3'd3 && s);
`endif
        fr = fr + {255'd0, inc};
        if (fr == (256'd1 << 112)) begin
            fr = 0;
            ex = ex + 1;
        end
        if (ex >= 32767) begin
            ro = maxf ? {s, 15'h7FFE, {112{1'b1}}} : {s, 15'h7FFF, 112'd0};
            rf = 3'b101;
        end else if (ex <= 0) begin
            ro = {s, 127'd0};
            rf = 3'b011;
        end else begin
            ro = {s, ex[14:0], fr[111:0]};
            rf = {2'b00, g | st};
        end
    endfunction

    // Issue one operation, scramble inputs while busy, wait for done and compare with the model.
    task automatic run_op(input string tag, input logic [255:0] p, input logic s,
                          input int e, input logic [2:0] r);
        logic [127:0] eo;
        logic [2:0]   ef;
        int           cyc;
        model(p, s, 18'(e), r, eo, ef);
        @(negedge clk);
        prod_i = p;
        sign_i = s;
        exp_i  = 18'(e);
        rm     = r;
        ld     = 1'b1;
        @(posedge clk);
        #1;
        ld     = 1'b0;
        prod_i = {30'd0, 226'(~p)};
        sign_i = ~s;
        exp_i  = ~exp_i;
        rm     = ~r;
        chk({tag, ".busy"}, {127'd0, busy}, 128'd1);
        cyc = 0;
        while (!done && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, ".latency"}, 128'(cyc), 128'd3);
        chk({tag, ".o"}, o, eo);
        chk({tag, ".flags"}, {125'd0, overflow, underflow, inexact}, {125'd0, ef});
    endtask

    initial begin
        logic [255:0] p;
        logic [112:0] a;
        logic [112:0] b;
        int           e;
        int           n;
        ncmp   = 0;
        nfail  = 0;
        rst_n  = 1'b0;
        ld     = 1'b0;
        prod_i = '0;
        sign_i = 1'b0;
        exp_i  = '0;
        rm     = '0;
        #12;
        chk("reset.o", o, 128'd0);
        chk("reset.ctl", {123'd0, done, busy, overflow, underflow, inexact}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0 * 1.0
        run_op("one", 256'd1 << 224, 1'b0, 16383, 3'd0);
        chk("one.const", o, {32'h3FFF0000, 96'd0});
        // 1.5 * 1.5
        run_op("onept5", 256'd9 << 222, 1'b0, 16383, 3'd0);
        chk("onept5.const", o, {32'h40002000, 96'd0});
        // RNE ties: to even stays, odd lsb rounds up
        run_op("tie_even", (256'd1 << 224) | (256'd1 << 111), 1'b0, 16383, 3'd0);
        chk("tie_even.const", {o, 1'b0} >> 1, {1'b0, 15'h3FFF, 112'd0});
        run_op("tie_odd", (256'd1 << 224) | (256'd1 << 112) | (256'd1 << 111), 1'b0, 16383,
               3'd0);
        chk("tie_odd.const", o, {1'b0, 15'h3FFF, 112'd2});
        // all-ones fraction rounding up carries into the exponent
        run_op("carry", (256'd1 << 225) - 256'd1, 1'b1, 16383, 3'd0);
        // exponent boundaries
        run_op("ovf", 256'd1 << 224, 1'b0, 32767, 3'd0);
        run_op("ovf_m1", 256'd1 << 224, 1'b0, 32766, 3'd0);
        run_op("unf", 256'd1 << 224, 1'b0, 0, 3'd0);
        run_op("unf_p1", 256'd1 << 224, 1'b0, 1, 3'd0);
        run_op("zero", 256'd0, 1'b1, 20000, 3'd0);
        chk("zero.const", o, {1'b1, 127'd0});

        // ld held high while busy: exactly one done
        @(negedge clk);
        prod_i = 256'd0;
        sign_i = 1'b1;
        exp_i  = 18'd100;
        ld     = 1'b1;
        @(posedge clk);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) ld = 1'b0;
            if (done) n++;
        end
        chk("ld_held.dones", 128'(n), 128'd1);

        // reset during NORM abandons the operation
        run_op("pre_rst", 256'd3 << 223, 1'b0, 16000, 3'd0);
        @(negedge clk);
        prod_i = 256'd1 << 224;
        exp_i  = 18'd16383;
        ld     = 1'b1;
        @(posedge clk);
        #1;
        ld    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.busy", {127'd0, busy}, 128'd0);
        chk("rst_mid.o", o, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
        chk("rst_mid.dones", 128'(n), 128'd0);

        // random products of normal significands
        for (int i = 0; i < 60; i++) begin
            a = {1'b1, 112'({$urandom, $urandom, $urandom, $urandom})};
            b = {1'b1, 112'({$urandom, $urandom, $urandom, $urandom})};
            if (i % 7 == 3) b = {1'b1, 112'd0};
            p = 256'(a) * 256'(b);
            case ($urandom_range(0, 5))
                0:       e = $urandom_range(0, 3) - 2;
                1:       e = 32764 + $urandom_range(0, 4);
                default: e = $urandom_range(1, 32766);
            endcase
            run_op("rand", p, 1'($urandom), e, 3'($urandom_range(0, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
